// File: rtl/rv32i_run_ctrl.sv
// Run sequencer for rv32i_core: optional memory/regfile clear, reset hold,
// run with ecall grading against gp, and a run-cycle timeout.
module rv32i_run_ctrl #(
    parameter int          MEM_WORDS      = 4096,
    parameter int          RESET_CYCLES   = 10,
    parameter int          TIMEOUT_CYCLES = 5000,
    parameter logic [31:0] PASS_VALUE     = 32'h1,
    localparam int         AW             = $clog2(MEM_WORDS),
    localparam int         RCW            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           start_clear,
    input  logic           halt_req,
    input  logic           core_is_ecall,
    input  logic [31:0]    core_gp,
    output logic           core_rst_n,
    output logic           mem_clr_we,
    output logic [AW-1:0]  mem_clr_addr,
    output logic           rf_clr_we,
    output logic [4:0]     rf_clr_addr,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic           fail,
    output logic           timeout,
    output logic [RCW-1:0] run_cycles
);
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [AW-1:0]  C_LAST    = AW'(MEM_WORDS - 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(RESET_CYCLES - 1);
    localparam logic [RCW-1:0] RUN_LAST  = RCW'(TIMEOUT_CYCLES - 1);
    // x1..x31 are cleared while the word counter is 0..30
    localparam logic [AW-1:0]  RF_LAST   = AW'(30);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_HOLD, S_RUN, S_DONE} state_t;

    state_t         r_state;
    logic [AW-1:0]  r_c;
    logic [HW-1:0]  r_hold;
    logic [RCW-1:0] r_run;

    logic           r_core_rst_n, r_mem_we, r_rf_we, r_busy, r_done;
    logic           r_pass, r_fail, r_timeout;
    logic [AW-1:0]  r_mem_addr;
    logic [4:0]     r_rf_addr;
    logic [RCW-1:0] r_run_cycles;

    logic w_gp_ok;
    assign w_gp_ok = (core_gp == PASS_VALUE);

    // Sequencer state, counters and registered outputs; halt_req behaves like a synchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_c          <= '0;
            r_hold       <= '0;
            r_run        <= '0;
            r_core_rst_n <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_run_cycles <= '0;
        end else if (halt_req) begin
            r_state      <= S_IDLE;
            r_c          <= '0;
            r_hold       <= '0;
            r_run        <= '0;
            r_core_rst_n <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_run_cycles <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_fail       <= 1'b0;
                        r_timeout    <= 1'b0;
                        r_run_cycles <= '0;
                        r_core_rst_n <= 1'b0;
                        r_c          <= '0;
                        r_hold       <= '0;
                        if (start_clear) begin
                            // first clear write is presented right away: word 0 and x1
                            r_state    <= S_CLEAR;
                            r_mem_we   <= 1'b1;
                            r_mem_addr <= '0;
                            r_rf_we    <= 1'b1;
                            r_rf_addr  <= 5'd1;
                        end else begin
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_CLEAR: begin
                    if (r_c == C_LAST) begin
                        r_state    <= S_HOLD;
                        r_hold     <= '0;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= '0;
                        r_rf_we    <= 1'b0;
                        r_rf_addr  <= '0;
                    end else begin
                        r_c        <= r_c + AW'(1);
                        r_mem_addr <= r_c + AW'(1);
                        r_rf_we    <= (r_c < RF_LAST);
                        r_rf_addr  <= (r_c < RF_LAST) ? 5'(r_c + AW'(2)) : 5'd0;
                    end
                end
                S_HOLD: begin
                    if (r_hold == HOLD_LAST) begin
                        r_state      <= S_RUN;
                        r_run        <= '0;
                        r_core_rst_n <= 1'b1;
                    end else begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                S_RUN: begin
                    // ecall is checked first so it wins on the final cycle
                    if (core_is_ecall || r_run == RUN_LAST) begin
                        r_state      <= S_DONE;
                        r_core_rst_n <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_run_cycles <= r_run + RCW'(1);
                        r_pass       <= core_is_ecall && w_gp_ok;
                        r_fail       <= core_is_ecall && !w_gp_ok;
                        r_timeout    <= !core_is_ecall;
                    end else begin
                        r_run <= r_run + RCW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign core_rst_n   = r_core_rst_n;
    assign mem_clr_we   = r_mem_we;
    assign mem_clr_addr = r_mem_addr;
    assign rf_clr_we    = r_rf_we;
    assign rf_clr_addr  = r_rf_addr;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign fail         = r_fail;
    assign timeout      = r_timeout;
    assign run_cycles   = r_run_cycles;

endmodule

// File: tb/tb_rv32i_run_ctrl.sv
// Bench for rv32i_run_ctrl: timeline model (outputs derived from edges elapsed
// since start) checked every cycle, plus directed literal expectations.
module tb_rv32i_run_ctrl;
    localparam int MW = 64, RC = 10, TO = 50;
    localparam int AW = 6, RCW = 6;

    logic           clk = 1'b0, rst_n = 1'b0;
    logic           start = 1'b0, start_clear = 1'b0, halt_req = 1'b0;
    logic           core_is_ecall = 1'b0;
    logic [31:0]    core_gp = 32'h0;
    logic           core_rst_n, mem_clr_we, rf_clr_we, busy, done, pass, fail, timeout;
    logic [AW-1:0]  mem_clr_addr;
    logic [4:0]     rf_clr_addr;
    logic [RCW-1:0] run_cycles;

    int errors = 0, checks = 0;

    rv32i_run_ctrl #(.MEM_WORDS(MW), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .PASS_VALUE(32'h1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_clear(start_clear),
        .halt_req(halt_req), .core_is_ecall(core_is_ecall), .core_gp(core_gp),
        .core_rst_n(core_rst_n), .mem_clr_we(mem_clr_we), .mem_clr_addr(mem_clr_addr),
        .rf_clr_we(rf_clr_we), .rf_clr_addr(rf_clr_addr), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .timeout(timeout), .run_cycles(run_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 active (clear/hold/run), 2 done
    int m_mode = 0, m_t = 0, m_E = 0, m_rc = 0;
    bit m_clr = 0, m_pass = 0, m_fail = 0, m_to = 0;

    function automatic int pre_len(bit c);
        return (c ? MW : 0) + RC;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_pass = 0; m_fail = 0; m_to = 0; m_rc = 0;
        end else begin
            int n, k;
            bit s_start, s_clr, s_halt, s_ecall;
            logic [31:0] s_gp;
            s_start = start; s_clr = start_clear; s_halt = halt_req;
            s_ecall = core_is_ecall; s_gp = core_gp;
            m_t++;
            if (s_halt) begin
                m_mode = 0; m_pass = 0; m_fail = 0; m_to = 0; m_rc = 0;
            end else if (m_mode != 1 && s_start) begin
                m_mode = 1; m_E = m_t; m_clr = s_clr;
                m_pass = 0; m_fail = 0; m_to = 0; m_rc = 0;
            end else if (m_mode == 1) begin
                n = m_t - m_E - pre_len(m_clr);   // RUN cycle number sampled at this edge
                if (n >= 1) begin
                    if (s_ecall) begin
                        m_mode = 2; m_rc = n;
                        m_pass = (s_gp == 32'h1); m_fail = (s_gp != 32'h1);
                    end else if (n == TO) begin
                        m_mode = 2; m_rc = TO; m_to = 1;
                    end
                end
            end
            #1;
            if (rst_n) begin
                bit act, e_mwe, e_rwe;
                k = m_t - m_E;
                act = (m_mode == 1);
                e_mwe = act && m_clr && k < MW;
                e_rwe = act && m_clr && k <= 30;
                chk("m_busy", busy, act);
                chk("m_done", done, m_mode == 2);
                chk("m_core_rst_n", core_rst_n, act && k >= pre_len(m_clr));
                chk("m_mem_we", mem_clr_we, e_mwe);
                chk("m_mem_addr", mem_clr_addr, e_mwe ? k : 0);
                chk("m_rf_we", rf_clr_we, e_rwe);
                chk("m_rf_addr", rf_clr_addr, e_rwe ? k + 1 : 0);
                chk("m_pass", pass, (m_mode == 2) && m_pass);
                chk("m_fail", fail, (m_mode == 2) && m_fail);
                chk("m_timeout", timeout, (m_mode == 2) && m_to);
                chk("m_run_cycles", run_cycles, (m_mode == 2) ? m_rc : 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input bit c);
        start = 1'b1; start_clear = c;
        @(negedge clk);
        start = 1'b0; start_clear = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!core_rst_n && n < 200) begin @(negedge clk); n++; end
        chk("wait_run", core_rst_n, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk("wait_done", done, 1);
    endtask

    // ecall presented so that RUN cycle n samples it
    task automatic ecall_at(input int n, input logic [31:0] gp);
        repeat (n - 1) @(negedge clk);
        core_is_ecall = 1'b1; core_gp = gp;
        @(negedge clk);
        core_is_ecall = 1'b0; core_gp = 32'h0;
    endtask

    initial begin
        int nm, nr, nh, guard;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_done", done, 0);

        // clear + hold
        do_start(1'b1);
        nm = 0; nr = 0; nh = 0; guard = 0;
        chk("clr_first_addr", mem_clr_addr, 0);
        chk("clr_first_rf", rf_clr_addr, 1);
        while (!core_rst_n && guard < 200) begin
            if (mem_clr_we) nm++;
            if (rf_clr_we) nr++;
            if (busy && !mem_clr_we && !core_rst_n) nh++;
            @(negedge clk); guard++;
        end
        chk("clr_mem_count", nm, 64);
        chk("clr_rf_count", nr, 31);
        chk("hold_count", nh, 10);
        chk("run_core_rst_n", core_rst_n, 1);
        halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
        chk("halt_run_busy", busy, 0);

        // pass
        do_start(1'b0);
        wait_run();
        ecall_at(7, 32'h1);
        chk("pass_done", done, 1);
        chk("pass_pass", pass, 1);
        chk("pass_rc", run_cycles, 7);
        chk("pass_core_rst_n", core_rst_n, 0);

        // restart from DONE, with a start ignored mid-RUN, graded as fail
        do_start(1'b0);
        chk("restart_pass_clr", pass, 0);
        chk("restart_done_clr", done, 0);
        chk("restart_busy", busy, 1);
        wait_run();
        @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("midrun_start_busy", busy, 1);
        ecall_at(5, 32'h5);
        chk("fail_fail", fail, 1);
        chk("fail_pass", pass, 0);
        chk("fail_rc", run_cycles, 7);

        // timeout
        do_start(1'b0);
        wait_done();
        chk("to_timeout", timeout, 1);
        chk("to_rc", run_cycles, 50);
        chk("to_pass", pass, 0);

        // ecall on the final cycle beats timeout
        do_start(1'b0);
        wait_run();
        ecall_at(50, 32'h1);
        chk("last_pass", pass, 1);
        chk("last_timeout", timeout, 0);
        chk("last_rc", run_cycles, 50);

        // halt during CLEAR at c=20
        do_start(1'b1);
        guard = 0;
        while (!(mem_clr_we && mem_clr_addr == 6'd20) && guard < 100) begin @(negedge clk); guard++; end
        chk("clr_at20", mem_clr_addr, 20);
        halt_req = 1'b1; @(negedge clk); halt_req = 1'b0;
        chk("hclr_busy", busy, 0);
        chk("hclr_mem_we", mem_clr_we, 0);
        chk("hclr_rf_we", rf_clr_we, 0);
        repeat (5) @(negedge clk);
        chk("hclr_still_idle", mem_clr_we, 0);

        // halt coincident with ecall
        do_start(1'b0);
        wait_run();
        repeat (2) @(negedge clk);
        halt_req = 1'b1; core_is_ecall = 1'b1; core_gp = 32'h1;
        @(negedge clk);
        halt_req = 1'b0; core_is_ecall = 1'b0; core_gp = 32'h0;
        chk("hec_done", done, 0);
        chk("hec_pass", pass, 0);
        chk("hec_busy", busy, 0);

        // async reset between edges mid-RUN
        do_start(1'b0);
        wait_run();
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_core_rst_n", core_rst_n, 0);
        chk("arst_busy", busy, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle", busy, 0);

        // recovers afterwards
        do_start(1'b0);
        wait_run();
        ecall_at(3, 32'h1);
        chk("recover_pass", pass, 1);
        chk("recover_rc", run_cycles, 3);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
